// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and defaults for the pc sequencer
package pc_sequencer_pkg;

  localparam int          DEFAULT_PC_W     = 2;
  localparam int unsigned DEFAULT_RESET_PC = 0;
  localparam int          DEFAULT_RET_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_PAUSE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - sequencer to fetch/decode/execute datapath bundle
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = DEFAULT_PC_W
) ();

  logic [PC_W-1:0] pc;
  logic            fetch_req;
  logic            decode_en;
  logic            exec_en;
  logic            mem_ready;
  logic            br_taken;
  logic [PC_W-1:0] br_target;

  modport master (
    output pc, fetch_req, decode_en, exec_en,
    input  mem_ready, br_taken, br_target
  );

  modport slave (
    input  pc, fetch_req, decode_en, exec_en,
    output mem_ready, br_taken, br_target
  );

endinterface

// File: rtl/pc_sequencer_pc_next_reg.sv
// rtl/pc_sequencer_pc_next_reg.sv - program counter register with increment or branch load
module pc_next_reg
  import pc_sequencer_pkg::*;
#(
  parameter int          PC_W     = DEFAULT_PC_W,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  // increment wraps naturally at 2^PC_W
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_W'(RESET_PC);
    end else if (en) begin
      pc <= load ? target : pc + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-cycle controller owning the program counter
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          PC_W     = DEFAULT_PC_W,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC,
  parameter int          RET_W    = DEFAULT_RET_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic               halt_req,
  pc_sequencer_if.master     dp,
  output logic               busy,
  output logic               halted,
  output logic [RET_W-1:0]   retired
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] FETCH  = ST_FETCH;
  localparam logic [2:0] DECODE = ST_DECODE;
  localparam logic [2:0] EXEC   = ST_EXEC;
  localparam logic [2:0] PAUSE  = ST_PAUSE;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic            halt_pend;
  logic            pc_en;
  logic [PC_W-1:0] pc_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (dp.mem_ready) state_nx = DECODE;
      DECODE:  state_nx = EXEC;
      EXEC: begin
        if (halt_pend || halt_req) state_nx = IDLE;
        else if (step_mode)        state_nx = PAUSE;
        else                       state_nx = FETCH;
      end
      PAUSE: begin
        if (halt_req)                state_nx = IDLE;
        else if (step || !step_mode) state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pc_en = (state == EXEC);

  pc_next_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .en     (pc_en),
    .load   (dp.br_taken),
    .target (dp.br_target),
    .pc     (pc_q)
  );

  assign dp.pc = pc_q;

  // strobes are registered from the next state so they align with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      halt_pend    <= 1'b0;
      retired      <= '0;
      dp.fetch_req <= 1'b0;
      dp.decode_en <= 1'b0;
      dp.exec_en   <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b1;
    end else begin
      state <= state_nx;
      if (state_nx == IDLE) begin
        halt_pend <= 1'b0;
      end else if (halt_req && (state == FETCH || state == DECODE)) begin
        halt_pend <= 1'b1;
      end
      if (state == EXEC) begin
        retired <= retired + 1'b1;
      end
      dp.fetch_req <= (state_nx == FETCH);
      dp.decode_en <= (state_nx == DECODE);
      dp.exec_en   <= (state_nx == EXEC);
      busy         <= (state_nx == FETCH) || (state_nx == DECODE) || (state_nx == EXEC);
      halted       <= (state_nx == IDLE);
    end
  end

endmodule
